// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Pops bytes from the receive FIFO, assembles little-endian 16-bit
//   instruction words (plus a trailing address word for STORE instructions
//   carrying the address flag in bit 4) and hands each complete instruction
//   to the controller over a valid/ready handshake. Illegal opcodes (6, 7)
//   are dropped with a one-cycle err_illegal pulse. Fetching stops after a
//   delivered HALT until flush.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   fifo_empty      receive FIFO empty flag
//   fifo_rdata      FIFO read data, valid the cycle after fifo_re
//   fifo_re         FIFO pop strobe
//   flush           synchronous abort/restart
//   instr_ready     controller accepts the presented instruction
//   instr_valid     instruction (and address, if any) valid
//   instr, opcode   assembled word and its opcode field
//   has_addr, addr  address present / low ADDRESS_SIZE bits of address word
//   err_illegal     one-cycle pulse when an illegal opcode is dropped
//   halted          HALT delivered, fetching stopped
//   busy            partial instruction in flight
//   instr_count     delivered instruction count (wraps)
module instr_fetch_unit #(
  parameter int FIFO_DATA_WIDTH  = 8,
  parameter int BUFFER_WORD_SIZE = 16,
  parameter int OPCODE_WIDTH     = 3,
  parameter int ADDRESS_SIZE     = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fifo_empty,
  input  logic [FIFO_DATA_WIDTH-1:0]  fifo_rdata,
  output logic                        fifo_re,
  input  logic                        flush,
  input  logic                        instr_ready,
  output logic                        instr_valid,
  output logic [BUFFER_WORD_SIZE-1:0] instr,
  output logic [OPCODE_WIDTH-1:0]     opcode,
  output logic                        has_addr,
  output logic [ADDRESS_SIZE-1:0]     addr,
  output logic                        err_illegal,
  output logic                        halted,
  output logic                        busy,
  output logic [15:0]                 instr_count
);

  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ILL_A = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_ILL_B = OPCODE_WIDTH'(7);
  localparam int STORE_ADDR_BIT = 4;

  typedef enum logic [2:0] {
    RD_INSTR_LO = 3'd0,
    RD_INSTR_HI = 3'd1,
    RD_ADDR_LO  = 3'd2,
    RD_ADDR_HI  = 3'd3,
    PRESENT     = 3'd4,
    HALTED      = 3'd5
  } state_t;

  state_t                        state_q, state_d;
  logic                          pending_q, pending_d;
  logic [BUFFER_WORD_SIZE-1:0]   instr_q, instr_d;
  logic [FIFO_DATA_WIDTH-1:0]    addr_lo_q, addr_lo_d;
  logic [ADDRESS_SIZE-1:0]       addr_q, addr_d;
  logic                          has_addr_q, has_addr_d;
  logic                          err_illegal_q, err_illegal_d;
  logic [15:0]                   count_q, count_d;

  logic                          rd_state_s;
  logic                          fifo_re_s;
  logic [OPCODE_WIDTH-1:0]       cur_op_s;

  assign cur_op_s = instr_q[OPCODE_WIDTH-1:0];

  // State register and datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RD_INSTR_LO;
      pending_q     <= 1'b0;
      instr_q       <= '0;
      addr_lo_q     <= '0;
      addr_q        <= '0;
      has_addr_q    <= 1'b0;
      err_illegal_q <= 1'b0;
      count_q       <= 16'd0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      instr_q       <= instr_d;
      addr_lo_q     <= addr_lo_d;
      addr_q        <= addr_d;
      has_addr_q    <= has_addr_d;
      err_illegal_q <= err_illegal_d;
      count_q       <= count_d;
    end
  end

  // Next-state, byte capture and pop-strobe logic.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    addr_lo_d     = addr_lo_q;
    addr_d        = addr_q;
    has_addr_d    = has_addr_q;
    count_d       = count_q;
    err_illegal_d = 1'b0;

    rd_state_s = (state_q == RD_INSTR_LO) || (state_q == RD_INSTR_HI) ||
                 (state_q == RD_ADDR_LO)  || (state_q == RD_ADDR_HI);
    // A byte is popped only when none is already in flight; rst gating keeps
    // the strobe low while reset is held even with a non-empty FIFO.
    fifo_re_s  = rd_state_s && !fifo_empty && !pending_q && !rst;
    pending_d  = fifo_re_s;

    if (flush) begin
      // A popped-but-uncaptured byte is abandoned; a handshake completing in
      // the same cycle still counts.
      state_d   = RD_INSTR_LO;
      pending_d = 1'b0;
      if ((state_q == PRESENT) && instr_ready) begin
        count_d = count_q + 16'd1;
      end else begin
        count_d = count_q;
      end
    end else begin
      case (state_q)
        RD_INSTR_LO: begin
          if (pending_q) begin
            instr_d = {{(BUFFER_WORD_SIZE-FIFO_DATA_WIDTH){1'b0}}, fifo_rdata};
            state_d = RD_INSTR_HI;
          end else begin
            state_d = RD_INSTR_LO;
          end
        end
        RD_INSTR_HI: begin
          if (pending_q) begin
            instr_d    = {fifo_rdata, instr_q[FIFO_DATA_WIDTH-1:0]};
            has_addr_d = 1'b0;
            // Opcode lives in the low byte, already captured.
            if ((cur_op_s == OP_ILL_A) || (cur_op_s == OP_ILL_B)) begin
              err_illegal_d = 1'b1;
              state_d       = RD_INSTR_LO;
            end else if ((cur_op_s == OP_STORE) && instr_q[STORE_ADDR_BIT]) begin
              state_d = RD_ADDR_LO;
            end else begin
              state_d = PRESENT;
            end
          end else begin
            state_d = RD_INSTR_HI;
          end
        end
        RD_ADDR_LO: begin
          if (pending_q) begin
            addr_lo_d = fifo_rdata;
            state_d   = RD_ADDR_HI;
          end else begin
            state_d = RD_ADDR_LO;
          end
        end
        RD_ADDR_HI: begin
          if (pending_q) begin
            // Upper address bits beyond ADDRESS_SIZE are dropped here.
            addr_d     = ADDRESS_SIZE'({fifo_rdata, addr_lo_q});
            has_addr_d = 1'b1;
            state_d    = PRESENT;
          end else begin
            state_d = RD_ADDR_HI;
          end
        end
        PRESENT: begin
          if (instr_ready) begin
            count_d = count_q + 16'd1;
            if (cur_op_s == OP_HALT) begin
              state_d = HALTED;
            end else begin
              state_d = RD_INSTR_LO;
            end
          end else begin
            state_d = PRESENT;
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = RD_INSTR_LO;
        end
      endcase
    end
  end

  assign fifo_re     = fifo_re_s;
  assign instr_valid = (state_q == PRESENT);
  assign instr       = instr_q;
  assign opcode      = cur_op_s;
  assign has_addr    = has_addr_q;
  assign addr        = addr_q;
  assign err_illegal = err_illegal_q;
  assign halted      = (state_q == HALTED);
  assign busy        = pending_q || (state_q == RD_INSTR_HI) || (state_q == RD_ADDR_LO) ||
                       (state_q == RD_ADDR_HI) || (state_q == PRESENT);
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a byte-queue FIFO model feeds the DUT, and
// a reference model built from the instruction list (word, address flag,
// address, legality) predicts every delivered instruction, the illegal
// pulse count and the delivered-instruction count.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        fifo_re;
  logic        flush;
  logic        instr_ready;
  logic        instr_valid;
  logic [15:0] instr;
  logic [2:0]  opcode;
  logic        has_addr;
  logic [9:0]  addr;
  logic        err_illegal;
  logic        halted;
  logic        busy;
  logic [15:0] instr_count;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_re(fifo_re), .flush(flush), .instr_ready(instr_ready),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode),
    .has_addr(has_addr), .addr(addr), .err_illegal(err_illegal),
    .halted(halted), .busy(busy), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Receive FIFO model: bytes written by the stimulus, popped on fifo_re.
  logic [7:0] fmem [0:4095];
  int push_cnt = 0;
  int pop_cnt  = 0;
  assign fifo_empty = (push_cnt == pop_cnt);
  initial fifo_rdata = 8'h00;

  always @(posedge clk) begin
    if (fifo_re && !fifo_empty) begin
      fifo_rdata <= fmem[pop_cnt[11:0]];
      pop_cnt    <= pop_cnt + 1;
    end
  end

  // Expected deliveries.
  logic [15:0] e_instr [0:1023];
  logic        e_has   [0:1023];
  logic [9:0]  e_addr  [0:1023];
  int exp_wr = 0;
  int exp_rd = 0;
  int exp_ill = 0;
  int ill_seen = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [15:0] model_cnt = 16'd0;
  bit mon_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // instr_ready driver: directed level or random.
  bit   rand_en  = 1'b0;
  logic ready_dir = 1'b1;
  initial begin
    instr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      instr_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_dir;
    end
  end

  // Monitor: protocol invariants, hold stability and delivery scoreboard.
  initial begin
    logic        hold_prev;
    logic [15:0] instr_prev;
    logic [9:0]  addr_prev;
    logic        has_prev;
    hold_prev = 1'b0;
    instr_prev = 16'h0;
    addr_prev = 10'h0;
    has_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_cnt   = 16'd0;
        hold_prev = 1'b0;
      end else if (mon_en) begin
        check("re_legal", 32'(fifo_re && (fifo_empty || instr_valid || halted)), 32'd0);
        check("count", 32'(instr_count), 32'(exp_cnt));
        if (hold_prev && instr_valid) begin
          check("hold_instr", 32'(instr), 32'(instr_prev));
          check("hold_has", 32'(has_addr), 32'(has_prev));
          check("hold_addr", 32'(addr), 32'(addr_prev));
        end
        if (err_illegal) ill_seen++;
        if (instr_valid && instr_ready) begin
          if (exp_rd == exp_wr) begin
            check("xfer_unexpected", 32'(exp_wr - exp_rd), 32'd1);
          end else begin
            check("xfer_instr", 32'(instr), 32'(e_instr[exp_rd]));
            check("xfer_opcode", 32'(opcode), 32'(e_instr[exp_rd][2:0]));
            check("xfer_has", 32'(has_addr), 32'(e_has[exp_rd]));
            if (e_has[exp_rd]) check("xfer_addr", 32'(addr), 32'(e_addr[exp_rd]));
            exp_rd++;
          end
          exp_cnt = exp_cnt + 16'd1;
        end
        hold_prev  = instr_valid && !instr_ready;
        instr_prev = instr;
        addr_prev  = addr;
        has_prev   = has_addr;
      end
    end
  end

  // Watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fmem[push_cnt[11:0]] = b;
    push_cnt++;
  endtask

  // Queue an instruction's bytes and its expected effect.
  task automatic send_instr(input logic [15:0] w, input logic [15:0] aw, input int gap_max);
    logic [2:0] op;
    logic       has;
    op  = w[2:0];
    has = (op == 3'd0) && w[4];
    if (op == 3'd6 || op == 3'd7) begin
      exp_ill++;
    end else begin
      e_instr[exp_wr] = w;
      e_has[exp_wr]   = has;
      e_addr[exp_wr]  = aw[9:0];
      exp_wr++;
      model_cnt = model_cnt + 16'd1;
    end
    push_byte(w[7:0]);
    repeat ($urandom_range(0, gap_max)) tick();
    push_byte(w[15:8]);
    if (has) begin
      repeat ($urandom_range(0, gap_max)) tick();
      push_byte(aw[7:0]);
      repeat ($urandom_range(0, gap_max)) tick();
      push_byte(aw[15:8]);
    end
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_rd == exp_wr && pop_cnt == push_cnt && !busy) break;
      tick();
    end
    check("drain_pending", 32'(exp_wr - exp_rd), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_re"}, 32'(fifo_re), 32'd0);
    check({pfx, "_valid"}, 32'(instr_valid), 32'd0);
    check({pfx, "_instr"}, 32'(instr), 32'd0);
    check({pfx, "_opcode"}, 32'(opcode), 32'd0);
    check({pfx, "_has"}, 32'(has_addr), 32'd0);
    check({pfx, "_addr"}, 32'(addr), 32'd0);
    check({pfx, "_err"}, 32'(err_illegal), 32'd0);
    check({pfx, "_halted"}, 32'(halted), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_count"}, 32'(instr_count), 32'd0);
  endtask

  initial begin
    logic [15:0] halt_cnt;
    rst   = 1'b1;
    flush = 1'b0;
    repeat (2) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // RUN 0x4002: pops in cycles 0 and 2, valid in cycle 4.
    tick();
    send_instr(16'h4002, 16'h0000, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("run_re", 32'(fifo_re), 32'(c == 0 || c == 2));
      check("run_valid", 32'(instr_valid), 32'(c == 4));
      if (c == 4) begin
        check("run_instr", 32'(instr), 32'h4002);
        check("run_opcode", 32'(opcode), 32'd2);
        check("run_has", 32'(has_addr), 32'd0);
      end
      if (c == 5) check("run_count", 32'(instr_count), 32'd1);
    end

    // STORE with address: pops 0,2,4,6, valid in cycle 8, addr 0x234.
    tick();
    send_instr(16'h0010, 16'hFE34, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("st_re", 32'(fifo_re), 32'(c == 0 || c == 2 || c == 4 || c == 6));
      check("st_valid", 32'(instr_valid), 32'(c == 8));
      if (c == 8) begin
        check("st_instr", 32'(instr), 32'h0010);
        check("st_has", 32'(has_addr), 32'd1);
        check("st_addr", 32'(addr), 32'h234);
      end
    end

    // Illegal 0x0007 dropped, NOP 0x0005 follows.
    tick();
    send_instr(16'h0007, 16'h0000, 0);
    send_instr(16'h0005, 16'h0000, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("ill_err", 32'(err_illegal), 32'(c == 4));
      check("ill_valid", 32'(instr_valid), 32'(c == 8));
      if (c == 4) check("ill_resume_re", 32'(fifo_re), 32'd1);
      if (c == 8) check("ill_nop", 32'(instr), 32'h0005);
      if (c == 9) check("ill_count", 32'(instr_count), 32'd3);
    end

    // Back-pressure: held stable, no pops while presenting.
    tick();
    ready_dir = 1'b0;
    send_instr(16'h1A01, 16'h0000, 0);
    send_instr(16'h0005, 16'h0000, 0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (instr_valid) break;
    end
    check("bp_valid", 32'(instr_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_re", 32'(fifo_re), 32'd0);
      check("bp_instr", 32'(instr), 32'h1A01);
    end
    tick();
    ready_dir = 1'b1;
    wait_drain(100);

    // HALT then queued NOP: stays halted until flush.
    tick();
    send_instr(16'h0004, 16'h0000, 0);
    halt_cnt = model_cnt;
    send_instr(16'h0005, 16'h0000, 0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (halted) break;
    end
    check("halt_reached", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("halt_hold", 32'(halted), 32'd1);
      check("halt_re", 32'(fifo_re), 32'd0);
      check("halt_valid", 32'(instr_valid), 32'd0);
    end
    check("halt_count", 32'(instr_count), 32'(halt_cnt));
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_halted", 32'(halted), 32'd0);
    check("flush_count", 32'(instr_count), 32'(halt_cnt));
    wait_drain(100);

    // Partial byte then flush: byte discarded, LOAD delivered next.
    tick();
    push_byte(8'h01);
    repeat (6) tick();
    @(negedge clk);
    check("part_busy", 32'(busy), 32'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("part_flush_busy", 32'(busy), 32'd0);
    tick();
    send_instr(16'h0003, 16'h0000, 0);
    wait_drain(100);

    // Reset mid-word: asynchronous clear to reset values.
    push_byte(8'h01);
    repeat (4) tick();
    check("rst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    model_cnt = 16'd0;
    #1;
    check_reset_vals("midrst");
    tick();
    rst = 1'b0;
    tick();
    send_instr(16'h0003, 16'h0000, 0);
    wait_drain(100);
    check("rst_load_count", 32'(instr_count), 32'd1);

    // Randomized instruction stream with byte gaps and random ready.
    rand_en = 1'b1;
    for (int k = 0; k < 60; k++) begin
      int          pick;
      logic [15:0] w;
      logic [15:0] aw;
      pick = $urandom_range(0, 6);
      w    = 16'($urandom);
      aw   = 16'($urandom);
      w[2:0] = (pick >= 4) ? 3'(pick + 1) : 3'(pick);
      send_instr(w, aw, 3);
      repeat ($urandom_range(0, 4)) tick();
    end
    wait_drain(3000);
    rand_en = 1'b0;
    tick();

    check("final_count", 32'(instr_count), 32'(model_cnt));
    check("illegal_pulses", 32'(ill_seen), 32'(exp_ill));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
